seg_display_arbiter: RTL and testbench
======================================

// Module: seg_display_arbiter
// PURPOSE
//  Shares the single 7-segment display (and its mirror LEDs) between up to NUM_REQ nibble
//  sources (auto counter, switch counter, bit counter, ...).
//  Uses round-robin scheduling with a fixed dwell time per owner and a blanking gap between owners.
//  Sits between the nibble producers and the nibble-to-7SD decoder.
//  Replaces hard-wired mode muxing with request-driven ownership.
// PARAMETERS
//  NUM_REQ       4           number of requesters, legal range 2..8
//  DWELL_CYCLES  25_000_000  cycles an owner keeps the display (1 s at 25 MHz)
//  GAP_CYCLES    2_500_000   blank cycles between owners (0.1 s); 0 = no gap
// PORTS
//  i_Clk      in   1           system clock
//  i_Rst_L    in   1           asynchronous active-low reset
//  i_Req      in   NUM_REQ     per-source display request, level-sensitive
//  i_Nibbles  in   4*NUM_REQ   source k nibble at [4k+3:4k]
//  i_Hold     in   1           1 = freeze dwell/gap timer (owner kept, no rotation)
//  o_Grant    out  NUM_REQ     one-hot current owner; 0 when none
//  o_Owner    out  3           index of current owner; valid only while o_Valid=1
//  o_Valid    out  1           1 = o_Nibble must be displayed; 0 = blank display
//  o_Nibble   out  4           owner's nibble, registered
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer = NUM_REQ-1, so source 0 is searched first.
//  All outputs are registered. Each nibble is a 1-cycle copy of i_Nibbles[owner].
//  FSM states:
//  - IDLE: o_Valid=0, o_Grant=0.
//    If any i_Req=1, go to SHOW with the next requester after the pointer (circular search).
//    o_Grant/o_Valid rise 1 cycle after i_Req is sampled.
//  - SHOW: o_Valid=1, o_Grant=onehot(owner).
//    Dwell counter counts 0..DWELL_CYCLES-1 and increments only when i_Hold=0.
//    At terminal count:
//    - if another source requests, go to GAP (or straight to the next owner if GAP_CYCLES=0);
//    - if only the owner requests, restart the dwell counter and stay;
//    - if nobody requests, go to IDLE.
//    Owner drops i_Req mid-dwell: leave SHOW next cycle (GAP if others request, else IDLE).
//  - GAP: o_Valid=0, o_Nibble=0, o_Grant=0.
//    Counts GAP_CYCLES (frozen by i_Hold), then picks the next requester after the previous owner.
//    If no requests remain at the end of GAP, go to IDLE.
//    Requests arriving during GAP are eligible at the end of GAP.
//  - The pointer updates to the owner on every entry to SHOW.
//    Starvation-free: each persistent requester is served within NUM_REQ dwells.
//  Simultaneous events:
//  - owner drop and terminal count in the same cycle: treated as a drop.
//  - i_Hold does not block a drop or the IDLE->SHOW transition.
//  Counter width: $clog2(max(DWELL_CYCLES,GAP_CYCLES)+1). One shared counter, cleared on every state change.
//  i_Req bits at or above NUM_REQ do not exist. o_Owner is zero-extended.
//  Async reset mid-SHOW: outputs clear immediately; the next grant restarts from source 0.
// STRUCTURE
//  Shared header seg_display_arbiter.vh: ARB_IDLE/ARB_SHOW/ARB_GAP state encodings (2 bits) and ARB_STATE_WIDTH.
//  Sub-module rr_next_picker (combinational): inputs i_Req, pointer; outputs next index and found flag.
//  Top-level display glue: replaces the state-based r_Nibble mux.
//  o_Valid=0 drives segments blank; o_Nibble feeds the 7SD decoder.
// TESTING  (bench uses DWELL_CYCLES=8, GAP_CYCLES=2, NUM_REQ=4)
//  1. Reset:
//     - hold i_Rst_L=0 with i_Req=4'b1111 -> all outputs 0.
//     - release -> o_Grant=4'b0001, o_Valid=1 one cycle later.
//  2. Rotation:
//     - i_Req=4'b1011, nibbles 1,2,3,4 -> owners 0,1,3,0 in turn, each valid 8 cycles;
//       2 blank cycles between owners.
//     - o_Nibble follows the owner: 1, 2, then 4.
//  3. Sole requester: i_Req=4'b0100 for 40 cycles -> o_Grant stays 4'b0100, o_Valid never drops.
//  4. Drop mid-dwell:
//     - owner 0 deasserts at dwell count 3 with i_Req[2]=1 -> 2-cycle gap, then owner 2.
//     - with no other request -> IDLE, o_Valid=0 next cycle.
//  5. Hold: i_Hold=1 for 20 cycles mid-SHOW -> owner held; rotation occurs 20 cycles later than without hold.
//  6. Reset mid-operation: i_Rst_L pulsed low while owner=3 -> outputs 0 asynchronously;
//     the next grant goes to source 0.

Source files
------------

// File: rtl/seg_display_arbiter_pkg.sv
// Shared types and constants for the 7-segment display arbiter.
package seg_display_arbiter_pkg;

  localparam int unsigned ARB_STATE_WIDTH = 2;
  localparam int unsigned OWNER_W         = 3;

  typedef enum logic [ARB_STATE_WIDTH-1:0] {
    ARB_IDLE = 2'd0,
    ARB_SHOW = 2'd1,
    ARB_GAP  = 2'd2
  } arb_state_t;

  function automatic int unsigned f_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg_display_arbiter_rr_next_picker.sv
// Combinational round-robin search: first requester strictly after the pointer,
// wrapping around so the pointer's own source is considered last.
module rr_next_picker
  import seg_display_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_Req,
  input  logic [OWNER_W-1:0] i_Ptr,
  output logic [OWNER_W-1:0] o_Idx,
  output logic               o_Found
);

  logic [2*NUM_REQ-1:0] w_Dbl;
  logic [NUM_REQ-1:0]   w_Rot;
  int unsigned          w_Sum;

  // Rotate requests so bit 0 is the source immediately after the pointer.
  always_comb begin
    w_Dbl = {i_Req, i_Req} >> ({1'b0, i_Ptr} + 4'd1);
    w_Rot = w_Dbl[NUM_REQ-1:0];
  end

  // Scan far-to-near so the nearest requester overwrites the result last.
  always_comb begin
    o_Idx   = '0;
    o_Found = 1'b0;
    w_Sum   = 0;
    for (int unsigned m = NUM_REQ; m > 0; m--) begin
      if (w_Rot[m-1]) begin
        w_Sum = 32'(i_Ptr) + m;
        if (w_Sum >= NUM_REQ) w_Sum = w_Sum - NUM_REQ;
        o_Idx   = OWNER_W'(w_Sum);
        o_Found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the shared 7-segment display: fixed dwell per owner,
// optional blank gap between owners, registered outputs.
module seg_display_arbiter
  import seg_display_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DWELL_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES   = 2_500_000
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  input  logic [NUM_REQ-1:0]   i_Req,
  input  logic [4*NUM_REQ-1:0] i_Nibbles,
  input  logic                 i_Hold,
  output logic [NUM_REQ-1:0]   o_Grant,
  output logic [OWNER_W-1:0]   o_Owner,
  output logic                 o_Valid,
  output logic [3:0]           o_Nibble
);

  localparam int unsigned        CNT_W      = $clog2(f_max(DWELL_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CNT_W-1:0]   DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic [NUM_REQ-1:0] ONE        = NUM_REQ'(1);

  arb_state_t          r_State, w_NextState;
  logic [CNT_W-1:0]    r_Cnt, w_CntNext;
  logic [OWNER_W-1:0]  r_Owner, w_NextOwner;
  logic [OWNER_W-1:0]  r_Ptr;
  logic                w_Load;
  logic [OWNER_W-1:0]  w_PickIdx;
  logic                w_PickFound;
  logic [NUM_REQ-1:0]  w_OwnerMask;
  logic                w_OwnerReq;
  logic                w_Others;
  logic [NUM_REQ-1:0]  w_GrantNext;
  logic [OWNER_W-1:0]  w_OwnerNext;
  logic                w_ValidNext;
  logic [3:0]          w_NibbleNext;

  rr_next_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .i_Req   (i_Req),
    .i_Ptr   (r_Ptr),
    .o_Idx   (w_PickIdx),
    .o_Found (w_PickFound)
  );

  // Owner's own request and whether anyone else is waiting.
  always_comb begin
    w_OwnerMask = ONE << r_Owner;
    w_OwnerReq  = |(i_Req & w_OwnerMask);
    w_Others    = |(i_Req & ~w_OwnerMask);
  end

  // State, shared counter, owner and round-robin pointer registers.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_State <= ARB_IDLE;
      r_Cnt   <= '0;
      r_Owner <= '0;
      r_Ptr   <= OWNER_W'(NUM_REQ - 1);
    end else begin
      r_State <= w_NextState;
      r_Cnt   <= w_CntNext;
      r_Owner <= w_NextOwner;
      if (w_Load) r_Ptr <= w_NextOwner;
    end
  end

  // Next-state logic; a drop outranks terminal count and ignores i_Hold.
  // The pointer always equals the owner in SHOW, so one picker serves all states.
  always_comb begin
    w_NextState = r_State;
    w_NextOwner = r_Owner;
    w_CntNext   = r_Cnt;
    w_Load      = 1'b0;
    case (r_State)
      ARB_IDLE: begin
        if (w_PickFound) begin
          w_NextState = ARB_SHOW;
          w_NextOwner = w_PickIdx;
          w_Load      = 1'b1;
          w_CntNext   = '0;
        end
      end
      ARB_SHOW: begin
        if (!w_OwnerReq || (!i_Hold && (r_Cnt == DWELL_LAST))) begin
          w_CntNext = '0;
          if (w_Others) begin
            if (GAP_CYCLES == 0) begin
              w_NextOwner = w_PickIdx;
              w_Load      = 1'b1;
            end else begin
              w_NextState = ARB_GAP;
            end
          end else if (!w_OwnerReq) begin
            w_NextState = ARB_IDLE;
          end
        end else if (!i_Hold) begin
          w_CntNext = r_Cnt + CNT_W'(1);
        end
      end
      ARB_GAP: begin
        if (!i_Hold) begin
          if (r_Cnt == GAP_LAST) begin
            w_CntNext = '0;
            if (w_PickFound) begin
              w_NextState = ARB_SHOW;
              w_NextOwner = w_PickIdx;
              w_Load      = 1'b1;
            end else begin
              w_NextState = ARB_IDLE;
            end
          end else begin
            w_CntNext = r_Cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_NextState = ARB_IDLE;
        w_CntNext   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so registered outputs line up with it.
  always_comb begin
    w_ValidNext  = (w_NextState == ARB_SHOW);
    w_GrantNext  = '0;
    w_OwnerNext  = '0;
    w_NibbleNext = '0;
    if (w_ValidNext) begin
      w_GrantNext = ONE << w_NextOwner;
      w_OwnerNext = w_NextOwner;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (w_NextOwner == OWNER_W'(k)) w_NibbleNext = i_Nibbles[4*k +: 4];
      end
    end
  end

  // Output registers; blank (all zero) whenever nothing is shown.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_Grant  <= '0;
      o_Owner  <= '0;
      o_Valid  <= 1'b0;
      o_Nibble <= '0;
    end else begin
      o_Grant  <= w_GrantNext;
      o_Owner  <= w_OwnerNext;
      o_Valid  <= w_ValidNext;
      o_Nibble <= w_NibbleNext;
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with DWELL=8, GAP=2, NUM_REQ=4.
module tb_seg_display_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] nibbles;
  logic        hold;
  logic [3:0]  grant;
  logic [2:0]  owner;
  logic        valid;
  logic [3:0]  nib;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [3:0] grant;
    logic       valid;
    logic [2:0] owner;
    logic [3:0] nib;
  } exp_t;

  exp_t sb[$];

  seg_display_arbiter #(
    .NUM_REQ      (4),
    .DWELL_CYCLES (8),
    .GAP_CYCLES   (2)
  ) dut (
    .i_Clk     (clk),
    .i_Rst_L   (rst_n),
    .i_Req     (req),
    .i_Nibbles (nibbles),
    .i_Hold    (hold),
    .o_Grant   (grant),
    .o_Owner   (owner),
    .o_Valid   (valid),
    .o_Nibble  (nib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, "/grant"}, 8'(grant), 8'h00);
    chk({tag, "/valid"}, 8'(valid), 8'h00);
    chk({tag, "/owner"}, 8'(owner), 8'h00);
    chk({tag, "/nibble"}, 8'(nib), 8'h00);
  endtask

  // Push the expectation for the next edge, advance one clock, then pop and compare.
  task automatic tick(input string tag, input logic [3:0] g, input logic v,
                      input logic [2:0] own, input logic [3:0] nb);
    exp_t e;
    e.tag = tag; e.grant = g; e.valid = v; e.owner = own; e.nib = nb;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, "/grant"}, 8'(grant), 8'(e.grant));
    chk({e.tag, "/valid"}, 8'(valid), 8'(e.valid));
    chk({e.tag, "/nibble"}, 8'(nib), 8'(e.nib));
    if (e.valid) chk({e.tag, "/owner"}, 8'(owner), 8'(e.owner));
  endtask

  task automatic show(input string tag, input int unsigned own, input int unsigned n,
                      input logic [3:0] nb);
    for (int unsigned i = 0; i < n; i++) tick(tag, 4'(1 << own), 1'b1, 3'(own), nb);
  endtask

  task automatic blank(input string tag, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick(tag, 4'b0000, 1'b0, 3'd0, 4'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    req     = 4'b1111;
    nibbles = 16'h4321;
    hold    = 1'b0;

    // 1. Reset holds everything at zero, first grant goes to source 0
    repeat (3) @(posedge clk);
    #1;
    chk_blank("rst_hold");
    rst_n = 1'b1;
    tick("rst_release", 4'b0001, 1'b1, 3'd0, 4'd1);

    // 2. Rotation 0 -> 1 -> 3 -> 0 with 2-cycle gaps
    req = 4'b1011;
    show("rot_o0", 0, 7, 4'd1);
    blank("rot_gap0", 2);
    show("rot_o1", 1, 8, 4'd2);
    blank("rot_gap1", 2);
    show("rot_o3", 3, 8, 4'd4);
    blank("rot_gap3", 2);
    show("rot_o0b", 0, 8, 4'd1);
    blank("rot_gap0b", 1);

    // 3. Sole requester (arrives during gap) keeps the display indefinitely
    req = 4'b0100;
    blank("sole_gap", 1);
    show("sole_o2", 2, 40, 4'd3);

    // 4. Drop mid-dwell: to another requester, then to nobody
    req = 4'b0101;
    blank("drop_gap_in", 2);
    show("drop_o0", 0, 4, 4'd1);
    req = 4'b0100;
    blank("drop_gap", 2);
    show("drop_o2", 2, 3, 4'd3);
    req = 4'b0000;
    blank("drop_idle", 2);

    // 5. Hold freezes the dwell for 20 cycles
    req = 4'b0011;
    show("hold_pre", 0, 3, 4'd1);
    hold = 1'b1;
    show("hold_on", 0, 20, 4'd1);
    hold = 1'b0;
    show("hold_post", 0, 5, 4'd1);
    blank("hold_gap", 2);
    show("hold_o1", 1, 8, 4'd2);

    // 6. Asynchronous reset while source 3 owns the display
    req = 4'b1000;
    blank("mid_gap", 2);
    show("mid_o3", 3, 3, 4'd4);
    req = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    chk_blank("async_rst");
    @(posedge clk);
    #1;
    chk_blank("async_rst_held");
    rst_n = 1'b1;
    tick("after_rst", 4'b0001, 1'b1, 3'd0, 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
